// File: rtl/otter_sim_pkg.sv
// Shared types for the OTTER simulation/bring-up run controller.
package otter_sim_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReset,
        StRun,
        StDone
    } run_state_t;

    typedef enum logic [1:0] {
        FcNone    = 2'b00,
        FcSigFail = 2'b01,
        FcTimeout = 2'b10
    } fail_code_t;

endpackage

// File: rtl/obs_stable_detect.sv
// Tracks how many consecutive identical samples of obs have been seen, saturating at
// STABLE_CYCLES; stable flags the sample that completes (or extends) a full-length run.
module obs_stable_detect #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] obs,
    output logic             stable,
    output logic [WIDTH-1:0] value
);

    localparam int unsigned LenW = $clog2(STABLE_CYCLES + 1);
    localparam logic [LenW-1:0] LenMax = LenW'(STABLE_CYCLES);

    logic [LenW-1:0]  len_q, len_d;
    logic [WIDTH-1:0] prev_q;

    // len_q == 0 means no sample taken since clear, so the first sample always restarts at 1.
    always_comb begin
        len_d = len_q;
        if (len_q == '0 || obs != prev_q) begin
            len_d = LenW'(1);
        end else if (len_q != LenMax) begin
            len_d = len_q + 1'b1;
        end
    end

    assign stable = sample_en && (len_d == LenMax);
    assign value  = obs;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            len_q  <= '0;
            prev_q <= '0;
        end else if (sample_en) begin
            len_q  <= len_d;
            prev_q <= obs;
        end
    end

endmodule

// File: rtl/otter_run_monitor.sv
// Run controller: holds the DUT in reset, releases it, then waits for a stable PASS/FAIL
// signature on obs or a timeout, and latches the verdict.
module otter_run_monitor
    import otter_sim_pkg::*;
#(
    parameter int unsigned     WIDTH         = 16,
    parameter int unsigned     RST_CYCLES    = 4,
    parameter int unsigned     TIMEOUT       = 1000,
    parameter int unsigned     STABLE_CYCLES = 3,
    parameter logic [WIDTH-1:0] PASS_VALUE   = 16'hC0DE,
    parameter logic [WIDTH-1:0] FAIL_VALUE   = 16'hDEAD,
    parameter int unsigned     CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] obs,
    output logic             dut_rst,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycles,
    output logic [WIDTH-1:0] last_obs
);

    localparam int unsigned     HoldW      = $clog2(RST_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldLast  = HoldW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    run_state_t       state_q, state_d;
    fail_code_t       fc_q, fc_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cycles_q, cycles_d, cycles_inc;
    logic [WIDTH-1:0] last_q, last_d;
    logic             pass_q, pass_d;
    logic             dut_rst_q, running_q, done_q;
    logic             det_clr, det_en, det_stable;
    logic [WIDTH-1:0] det_value;

    obs_stable_detect #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_detect (
        .clk      (clk),
        .rst      (rst),
        .clr      (det_clr),
        .sample_en(det_en),
        .obs      (obs),
        .stable   (det_stable),
        .value    (det_value)
    );

    assign cycles_inc = (cycles_q == CntMax) ? cycles_q : cycles_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cycles_d = cycles_q;
        pass_d   = pass_q;
        fc_d     = fc_q;
        last_d   = last_q;
        det_clr  = 1'b0;
        det_en   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StReset;
                    hold_d   = '0;
                    cycles_d = '0;
                    pass_d   = 1'b0;
                    fc_d     = FcNone;
                    last_d   = '0;
                    det_clr  = 1'b1;
                end
            end
            StReset: begin
                if (hold_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StRun: begin
                det_en   = 1'b1;
                cycles_d = cycles_inc;
                // Signature verdicts are checked first so they win over a coincident timeout.
                if (det_stable && det_value == PASS_VALUE) begin
                    state_d = StDone;
                    pass_d  = 1'b1;
                    fc_d    = FcNone;
                    last_d  = det_value;
                end else if (det_stable && det_value == FAIL_VALUE) begin
                    state_d = StDone;
                    fc_d    = FcSigFail;
                    last_d  = det_value;
                end else if (cycles_inc == TimeoutVal) begin
                    state_d = StDone;
                    fc_d    = FcTimeout;
                    last_d  = det_value;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            cycles_q  <= '0;
            pass_q    <= 1'b0;
            fc_q      <= FcNone;
            last_q    <= '0;
            dut_rst_q <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cycles_q  <= cycles_d;
            pass_q    <= pass_d;
            fc_q      <= fc_d;
            last_q    <= last_d;
            dut_rst_q <= (state_d != StRun);
            running_q <= (state_d == StRun);
            done_q    <= (state_d == StDone);
        end
    end

    assign dut_rst   = dut_rst_q;
    assign running   = running_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fc_q;
    assign cycles    = cycles_q;
    assign last_obs  = last_q;

endmodule

// File: tb/tb_otter_run_monitor.sv
// Self-checking bench for otter_run_monitor: directed scenarios plus random runs scored
// against a sample-history reference model.
module tb_otter_run_monitor;

    localparam int unsigned RST_C = 4;
    localparam int unsigned TMO   = 25;
    localparam int unsigned STB   = 3;
    localparam logic [15:0] PASSV = 16'hC0DE;
    localparam logic [15:0] FAILV = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] obs = '0;
    logic        dut_rst, running, done, pass;
    logic [1:0]  fail_code;
    logic [31:0] cycles;
    logic [15:0] last_obs;

    otter_run_monitor #(
        .WIDTH        (16),
        .RST_CYCLES   (RST_C),
        .TIMEOUT      (TMO),
        .STABLE_CYCLES(STB),
        .PASS_VALUE   (PASSV),
        .FAIL_VALUE   (FAILV),
        .CNT_W        (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .obs      (obs),
        .dut_rst  (dut_rst),
        .running  (running),
        .done     (done),
        .pass     (pass),
        .fail_code(fail_code),
        .cycles   (cycles),
        .last_obs (last_obs)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] stim [64];

    // Results of the most recent drive_run.
    int          r_reset_len, r_len;
    logic        r_done, r_pass, r_run_ok;
    logic [1:0]  r_fc;
    logic [31:0] r_cycles, r_first_cycles;
    logic [15:0] r_last;
    // Outputs seen on the first cycle after start was accepted.
    logic        s_done, s_pass, s_dut_rst;
    logic [1:0]  s_fc;
    logic [31:0] s_cycles;
    logic [15:0] s_last;

    int          e_len;
    logic        e_pass;
    logic [1:0]  e_fc;
    logic [15:0] e_last;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Verdict from the sample history: the first RUN sample that ends STB identical samples of
    // a signature decides; otherwise the TMO-th sample times out.
    task automatic model(output int len, output logic p, output logic [1:0] fc,
                         output logic [15:0] last);
        int k;
        len = TMO; p = 1'b0; fc = 2'b10; last = stim[TMO-1];
        for (int i = 0; i < int'(TMO); i++) begin
            k = 0;
            while (k <= i && stim[i-k] == stim[i]) k++;
            if (k >= int'(STB) && (stim[i] == PASSV || stim[i] == FAILV)) begin
                len = i + 1;
                p = (stim[i] == PASSV);
                fc = p ? 2'b00 : 2'b01;
                last = stim[i];
                return;
            end
        end
    endtask

    function automatic logic [15:0] rand_plain();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == PASSV || v == FAILV) v = v ^ 16'h0001;
        return v;
    endfunction

    task automatic gen_random();
        int r;
        for (int i = 0; i < 64; i++) begin
            r = int'($urandom_range(0, 9));
            if (i > 0 && r < 5) stim[i] = stim[i-1];
            else if (r < 7)     stim[i] = PASSV;
            else if (r < 9)     stim[i] = FAILV;
            else                stim[i] = rand_plain();
        end
    endtask

    // Called at posedge+1 in IDLE or DONE. start_at >= 0 pulses start on that RUN cycle.
    task automatic drive_run(input int start_at);
        int i;
        start = 1'b1;
        step();
        start = 1'b0;
        s_done = done; s_pass = pass; s_fc = fail_code; s_cycles = cycles;
        s_last = last_obs; s_dut_rst = dut_rst;
        r_reset_len = 0;
        while (dut_rst === 1'b1 && r_reset_len < 20) begin
            r_reset_len++;
            step();
        end
        r_first_cycles = cycles;
        r_run_ok = 1'b1;
        i = 0;
        while (done !== 1'b1 && i < int'(TMO) + 5) begin
            if (running !== 1'b1 || dut_rst !== 1'b0 || cycles !== 32'(i)) r_run_ok = 1'b0;
            obs = stim[i];
            start = (i == start_at);
            step();
            i++;
        end
        start = 1'b0;
        r_len = i; r_done = done; r_pass = pass; r_fc = fail_code;
        r_cycles = cycles; r_last = last_obs;
    endtask

    task automatic check_run(input string name);
        model(e_len, e_pass, e_fc, e_last);
        n_cmp++;
        if (r_reset_len !== int'(RST_C)) begin
            n_err++; $display("FAIL %s reset_len: got %0d expected %0d", name, r_reset_len, RST_C);
        end
        n_cmp++;
        if (r_first_cycles !== 32'd0 || r_run_ok !== 1'b1) begin
            n_err++; $display("FAIL %s run_phase: first_cycles %0d run_ok %0b expected 0/1", name,
                             r_first_cycles, r_run_ok);
        end
        n_cmp++;
        if (r_done !== 1'b1 || r_len !== e_len) begin
            n_err++; $display("FAIL %s verdict_time: done %0b after %0d expected 1 after %0d",
                             name, r_done, r_len, e_len);
        end
        n_cmp++;
        if (r_pass !== e_pass || r_fc !== e_fc) begin
            n_err++; $display("FAIL %s verdict: pass %0b code %b expected %0b %b", name, r_pass,
                             r_fc, e_pass, e_fc);
        end
        n_cmp++;
        if (r_cycles !== 32'(e_len) || r_last !== e_last) begin
            n_err++; $display("FAIL %s counts: cycles %0d last %h expected %0d %h", name,
                             r_cycles, r_last, e_len, e_last);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        n_cmp++;
        if ({dut_rst, running, done, pass, fail_code} !== 6'b100000 || cycles !== 0
            || last_obs !== 0) begin
            n_err++; $display("FAIL reset_values: got rst%0b run%0b done%0b pass%0b fc%b cyc%0d last%h",
                             dut_rst, running, done, pass, fail_code, cycles, last_obs);
        end
        for (int i = 0; i < 8; i++) begin
            obs = PASSV;
            step();
        end
        n_cmp++;
        if (dut_rst !== 1'b1 || done !== 1'b0 || running !== 1'b0 || cycles !== 0) begin
            n_err++; $display("FAIL idle_hold: got rst%0b done%0b run%0b cyc%0d expected 1 0 0 0",
                             dut_rst, done, running, cycles);
        end
    endtask

    task automatic test_pass_directed();
        for (int i = 0; i < 64; i++) stim[i] = (i < 3) ? 16'h1234 : PASSV;
        drive_run(-1);
        check_run("pass_directed");
        n_cmp++;
        if (r_len !== 6 || r_last !== PASSV) begin
            n_err++; $display("FAIL pass_latency: got %0d cycles expected 6", r_len);
        end
    endtask

    task automatic test_done_hold();
        for (int i = 0; i < 4; i++) begin
            obs = 16'($urandom);
            step();
        end
        n_cmp++;
        if (done !== 1'b1 || pass !== r_pass || fail_code !== r_fc || cycles !== r_cycles
            || last_obs !== r_last || dut_rst !== 1'b1 || running !== 1'b0) begin
            n_err++; $display("FAIL done_hold: got done%0b pass%0b fc%b cyc%0d last%h rst%0b",
                             done, pass, fail_code, cycles, last_obs, dut_rst);
        end
    endtask

    task automatic test_timeout_toggle();
        for (int i = 0; i < 64; i++) stim[i] = i[0] ? 16'h0000 : PASSV;
        drive_run(-1);
        check_run("timeout_toggle");
        n_cmp++;
        if (r_fc !== 2'b10 || r_cycles !== 32'd25) begin
            n_err++; $display("FAIL timeout_code: got fc %b cycles %0d expected 10 25", r_fc, r_cycles);
        end
    endtask

    task automatic test_fail_split();
        for (int i = 0; i < 64; i++) stim[i] = rand_plain();
        stim[0] = FAILV; stim[1] = FAILV; stim[2] = 16'h0001;
        stim[3] = FAILV; stim[4] = FAILV; stim[5] = FAILV;
        drive_run(-1);
        check_run("fail_split");
        n_cmp++;
        if (r_fc !== 2'b01 || r_len !== 6) begin
            n_err++; $display("FAIL fail_split_time: got fc %b after %0d expected 01 after 6",
                             r_fc, r_len);
        end
    endtask

    task automatic test_sig_vs_timeout();
        for (int i = 0; i < 64; i++) stim[i] = rand_plain();
        stim[21] = 16'h0BAD;
        stim[22] = PASSV; stim[23] = PASSV; stim[24] = PASSV;
        drive_run(-1);
        check_run("sig_vs_timeout");
        n_cmp++;
        if (r_pass !== 1'b1 || r_fc !== 2'b00 || r_cycles !== 32'd25) begin
            n_err++; $display("FAIL sig_wins: got pass %0b fc %b cycles %0d expected 1 00 25",
                             r_pass, r_fc, r_cycles);
        end
    endtask

    task automatic test_start_in_run();
        for (int i = 0; i < 64; i++) stim[i] = rand_plain();
        stim[10] = FAILV; stim[11] = FAILV; stim[12] = FAILV;
        drive_run(4);
        check_run("start_in_run");
    endtask

    task automatic test_start_in_done();
        gen_random();
        drive_run(-1);
        n_cmp++;
        if (s_done !== 1'b0 || s_pass !== 1'b0 || s_fc !== 2'b00 || s_cycles !== 0
            || s_last !== 0 || s_dut_rst !== 1'b1) begin
            n_err++; $display("FAIL restart_clear: got done%0b pass%0b fc%b cyc%0d last%h rst%0b",
                             s_done, s_pass, s_fc, s_cycles, s_last, s_dut_rst);
        end
        check_run("restart_run");
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            gen_random();
            drive_run(-1);
            check_run("random");
        end
    endtask

    task automatic test_rst_midrun();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (RST_C + 5) begin
            obs = rand_plain();
            step();
        end
        n_cmp++;
        if (running !== 1'b1) begin
            n_err++; $display("FAIL midrun_setup: running %0b expected 1", running);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({dut_rst, running, done, pass, fail_code} !== 6'b100000 || cycles !== 0
            || last_obs !== 0) begin
            n_err++; $display("FAIL midrun_reset: got rst%0b run%0b done%0b pass%0b fc%b cyc%0d",
                             dut_rst, running, done, pass, fail_code, cycles);
        end
        for (int i = 0; i < 10; i++) begin
            obs = PASSV;
            step();
        end
        n_cmp++;
        if (done !== 1'b0 || dut_rst !== 1'b1 || cycles !== 0) begin
            n_err++; $display("FAIL midrun_no_verdict: got done%0b rst%0b cyc%0d expected 0 1 0",
                             done, dut_rst, cycles);
        end
    endtask

    initial begin
        test_reset();
        test_pass_directed();
        test_done_hold();
        test_timeout_toggle();
        test_fail_split();
        test_sig_vs_timeout();
        test_start_in_run();
        test_start_in_done();
        test_random();
        test_rst_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/otter_run_monitor.md
# otter_run_monitor

Parametrised run controller and self-checking monitor for the OTTER pipeline. It replaces the fixed-delay, open-loop stimulus used so far. On `start` it holds the DUT in reset for a programmable number of cycles, then releases it and counts run cycles. It watches an observation bus (normally the wrapper's `leds`) for a stable PASS or FAIL signature, or flags a timeout. It is synthesizable, so the same block drives simulation benches and on-board bring-up.

## Interface
- `WIDTH`, 16: observation bus width.
- `RST_CYCLES`, 4: DUT reset hold length in cycles; must be ≥1.
- `TIMEOUT`, 1000: maximum RUN cycles before a timeout verdict; must be ≥1.
- `STABLE_CYCLES`, 3: consecutive identical samples required for a verdict; must be ≥1.
- `PASS_VALUE`, 16'hC0DE: pass signature, `WIDTH` bits.
- `FAIL_VALUE`, 16'hDEAD: fail signature, `WIDTH` bits; must differ from `PASS_VALUE`.
- `CNT_W`, 32: cycle counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle run request; honoured only in IDLE or DONE.
- `obs`  in  WIDTH  observed DUT output.
- `dut_rst`  out  1  reset driven to the DUT (wrapper `buttons[4]`).
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while `done`; high when the PASS signature was seen.
- `fail_code`  out  2  valid while `done`: 00 none, 01 FAIL signature, 10 timeout.
- `cycles`  out  CNT_W  RUN cycle count; saturates at all-ones.
- `last_obs`  out  WIDTH  `obs` sample on which the verdict was taken.

## Operation
- FSM states: IDLE, RESET, RUN, DONE.
- Reset values: state IDLE, `dut_rst`=1, `running`=0, `done`=0, `pass`=0, `fail_code`=00, `cycles`=0, `last_obs`=0, internal counters 0.
- IDLE: `dut_rst`=1. `start` moves to RESET.
- RESET: `dut_rst`=1 for exactly `RST_CYCLES` cycles, then moves to RUN. On entry it clears `cycles`, the run-length counter, `pass`, `fail_code` and `last_obs`.
- RUN: `dut_rst`=0 and `cycles` increments by 1 every cycle.
  - Stability detector: run length is set to 1 when `obs` differs from the previous sample (always 1 on the first RUN cycle) and increments when it is equal, saturating at `STABLE_CYCLES`.
  - When run length reaches `STABLE_CYCLES` and `obs`==`PASS_VALUE`, go to DONE with `pass`=1 and `fail_code`=00.
  - When run length reaches `STABLE_CYCLES` and `obs`==`FAIL_VALUE`, go to DONE with `pass`=0 and `fail_code`=01.
  - Otherwise, when `cycles` reaches `TIMEOUT`, go to DONE with `pass`=0 and `fail_code`=10.
  - `last_obs` captures `obs` on the deciding cycle.
- DONE: `dut_rst`=1 (freezes the DUT). All verdict outputs and `cycles` hold. `start` re-enters RESET.
- Priority when events coincide: signature verdict over timeout. In RESET or RUN, `start` is ignored.
- Reset asserted mid-run: next state is IDLE with all reset values; no verdict is produced.

## Timing
- `start` high at edge k: RESET occupies cycles k+1 … k+`RST_CYCLES`. `dut_rst` falls at edge k+`RST_CYCLES`+1, which is the first RUN cycle with `cycles`=0.
- All outputs are registered. There is no combinational path from `obs` or `start` to any output.
- Verdict latency: `done` rises one cycle after the sample that completes the stable run.
- Timeout: `done` rises with `cycles`=`TIMEOUT`, i.e. after exactly `TIMEOUT` RUN cycles.
- `STABLE_CYCLES`=1: a single matching sample decides.

## Structure
- Shared package `otter_sim_pkg`:
  - `run_state_t` enum (IDLE, RESET, RUN, DONE).
  - `fail_code_t` enum (NONE=2'b00, SIG_FAIL=2'b01, TIMEOUT=2'b10).
- One sub-module, `obs_stable_detect`:
  - Parameters: `WIDTH`, `STABLE_CYCLES`.
  - Ports: `clk`, `rst`, `clr`, `sample_en`, `obs`, `stable`, `value`.
  - Holds the previous-sample register and the saturating run-length counter.
- The top level holds the FSM, the reset-hold counter and the cycle counter.

## Test plan
All scenarios use RST_CYCLES=4, TIMEOUT=25, STABLE_CYCLES=3.
- Reset then idle: `dut_rst`=1, `done`=0, `cycles`=0 with `start` never pulsed.
- `start` at cycle 10: `dut_rst` high cycles 11–14, low from 15. `obs`=C0DE from cycle 18 → `done`=1, `pass`=1, `fail_code`=00, `last_obs`=C0DE at cycle 21.
- `obs` toggles C0DE/0000 each cycle: no verdict. Timeout → `done`, `fail_code`=10, `cycles`=25.
- `obs`=DEAD held for 2 cycles, then 0001, then DEAD held for 3 cycles: verdict `fail_code`=01 only after the second DEAD run.
- Signature completes on the same cycle that `cycles` reaches 25: `pass`=1 and `fail_code`=00 (signature wins over timeout).
- `rst` pulsed mid-RUN → IDLE with reset values. Pulse `start` in RUN → ignored. Pulse `start` in DONE → new RESET with `cycles` cleared.
